// File: rtl/lstm_gate_scheduler_pkg.sv
// Shared definitions for the LSTM gate scheduler.
// Contents: default sizing parameters, Q-format width helpers, gate bank
// indices and the scheduler FSM state encoding.
package lstm_gate_scheduler_pkg;

  localparam int HIDDEN_SZ_DEF   = 16;
  localparam int QN_DEF          = 6;
  localparam int QM_DEF          = 11;
  localparam int SEQ_W_DEF       = 8;
  localparam int TIMEOUT_CYC_DEF = 1024;

  // Width of one Q(QN.QM) element including the sign bit.
  function automatic int calc_bitwidth(input int qn, input int qm);
    return qn + qm + 1;
  endfunction

  // Width of a whole hidden-size vector of Q elements.
  function automatic int calc_layer_bitwidth(input int qn, input int qm, input int hidden);
    return calc_bitwidth(qn, qm) * hidden;
  endfunction

  // Weight/bias bank select values, in the order the gates are issued.
  localparam logic [1:0] GATE_I = 2'd0;
  localparam logic [1:0] GATE_F = 2'd1;
  localparam logic [1:0] GATE_C = 2'd2;
  localparam logic [1:0] GATE_O = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_X    = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_GATE = 3'd3,
    ST_CAPTURE   = 3'd4,
    ST_WAIT_ACK  = 3'd5,
    ST_DONE      = 3'd6
  } sched_state_e;

endpackage

// File: rtl/lstm_gate_scheduler_gate_watchdog.sv
// Watchdog for one gate computation.
// Counts cycles while enabled; expired_o flags the TIMEOUT_CYC-th counted
// cycle so the owner can abandon the computation on the following edge.
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous active-low reset
//   clear_i   restart the count from zero (wins over enable_i)
//   enable_i  count this cycle
//   expired_o high during the TIMEOUT_CYC-th enabled cycle since clear
module lstm_gate_scheduler_gate_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The cycle carrying count TIMEOUT_CYC-1 is the TIMEOUT_CYC-th counted cycle.
  assign expired_o = enable_i && (count_q == CNT_LAST);

endmodule

// File: rtl/lstm_gate_scheduler.sv
// LSTM gate scheduler: time-multiplexes one gate datapath over the
// input/forget/candidate/output gates for every step of a sequence.
// Ports:
//   clock, reset           clock (rising edge), async active-low reset
//   start, abort, seqLen   sequence control from the layer top
//   inputValid/inputReady  x(t) handshake
//   gateSel, beginCalc     bank select and start pulse to the shared gate
//   dataReady_gate, gateOutput  gate completion pulse and result
//   resultVec/Gate/Valid   registered gate result to the cell-update stage
//   cellAck                cell stage finished c(t)/h(t)
//   timeStep, busy, done, error  status
// All outputs come straight from registers.
module lstm_gate_scheduler
  import lstm_gate_scheduler_pkg::*;
#(
  parameter int HIDDEN_SZ   = HIDDEN_SZ_DEF,
  parameter int QN          = QN_DEF,
  parameter int QM          = QM_DEF,
  parameter int SEQ_W       = SEQ_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic                                        abort,
  input  logic [SEQ_W-1:0]                            seqLen,
  input  logic                                        inputValid,
  output logic                                        inputReady,
  output logic [1:0]                                  gateSel,
  output logic                                        beginCalc,
  input  logic                                        dataReady_gate,
  input  logic [calc_layer_bitwidth(QN, QM, HIDDEN_SZ)-1:0] gateOutput,
  output logic [calc_layer_bitwidth(QN, QM, HIDDEN_SZ)-1:0] resultVec,
  output logic [1:0]                                  resultGate,
  output logic                                        resultValid,
  input  logic                                        cellAck,
  output logic [SEQ_W-1:0]                            timeStep,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        error
);

  localparam int LAYER_BW = calc_layer_bitwidth(QN, QM, HIDDEN_SZ);

  sched_state_e         state_q, state_d;
  logic [SEQ_W-1:0]     seq_len_q, seq_len_d;
  logic [SEQ_W-1:0]     time_step_q, time_step_d;
  logic [1:0]           gate_sel_q, gate_sel_d;
  logic                 error_q, error_d;
  logic [LAYER_BW-1:0]  result_vec_q, result_vec_d;
  logic [1:0]           result_gate_q, result_gate_d;
  logic                 result_valid_q, result_valid_d;
  logic                 begin_calc_q, begin_calc_d;
  logic                 input_ready_q, input_ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 wd_clear_s;
  logic                 wd_enable_s;
  logic                 wd_expired_s;

  // The watchdog restarts on the edge where beginCalc rises, so it counts
  // cycles from the beginCalc pulse itself.
  assign wd_clear_s  = (state_d == ST_ISSUE);
  assign wd_enable_s = (state_q == ST_ISSUE) || (state_q == ST_WAIT_GATE);

  lstm_gate_scheduler_gate_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (wd_clear_s),
    .enable_i  (wd_enable_s),
    .expired_o (wd_expired_s)
  );

  // Next-state logic and next values of every registered output.
  always_comb begin
    state_d       = state_q;
    seq_len_d     = seq_len_q;
    time_step_d   = time_step_q;
    gate_sel_d    = gate_sel_q;
    error_d       = error_q;
    result_vec_d  = result_vec_q;
    result_gate_d = result_gate_q;

    if (abort) begin
      // abort wins over everything; error, result and step are left alone
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (seqLen != '0) begin
              state_d     = ST_WAIT_X;
              seq_len_d   = seqLen;
              time_step_d = '0;
              gate_sel_d  = GATE_I;
              error_d     = 1'b0;
            end else begin
              error_d = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_X: begin
          if (inputValid && input_ready_q) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_WAIT_X;
          end
        end
        ST_ISSUE: begin
          state_d = ST_WAIT_GATE;
        end
        ST_WAIT_GATE: begin
          // a reply in the last allowed cycle still counts as on time
          if (dataReady_gate) begin
            result_vec_d = gateOutput;
            state_d      = ST_CAPTURE;
          end else if (wd_expired_s) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_GATE;
          end
        end
        ST_CAPTURE: begin
          if (gate_sel_q == GATE_O) begin
            state_d = ST_WAIT_ACK;
          end else begin
            gate_sel_d = gate_sel_q + 2'd1;
            state_d    = ST_ISSUE;
          end
        end
        ST_WAIT_ACK: begin
          if (cellAck) begin
            gate_sel_d = GATE_I;
            if (time_step_q == (seq_len_q - SEQ_W'(1))) begin
              state_d = ST_DONE;
            end else begin
              time_step_d = time_step_q + SEQ_W'(1);
              state_d     = ST_WAIT_X;
            end
          end else begin
            state_d = ST_WAIT_ACK;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Capture holds gateSel unchanged, so it names the gate being reported.
    if (state_d == ST_CAPTURE) begin
      result_gate_d = gate_sel_q;
    end else begin
      result_gate_d = result_gate_q;
    end

    // Strobes and levels are decoded from the next state so the registered
    // copies line up exactly with the state they describe.
    result_valid_d = (state_d == ST_CAPTURE);
    begin_calc_d   = (state_d == ST_ISSUE);
    input_ready_d  = (state_d == ST_WAIT_X);
    busy_d         = (state_d != ST_IDLE);
    done_d         = (state_d == ST_DONE);
  end

  // State, counters and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      seq_len_q      <= '0;
      time_step_q    <= '0;
      gate_sel_q     <= GATE_I;
      error_q        <= 1'b0;
      result_vec_q   <= '0;
      result_gate_q  <= 2'd0;
      result_valid_q <= 1'b0;
      begin_calc_q   <= 1'b0;
      input_ready_q  <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      seq_len_q      <= seq_len_d;
      time_step_q    <= time_step_d;
      gate_sel_q     <= gate_sel_d;
      error_q        <= error_d;
      result_vec_q   <= result_vec_d;
      result_gate_q  <= result_gate_d;
      result_valid_q <= result_valid_d;
      begin_calc_q   <= begin_calc_d;
      input_ready_q  <= input_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign inputReady  = input_ready_q;
  assign gateSel     = gate_sel_q;
  assign beginCalc   = begin_calc_q;
  assign resultVec   = result_vec_q;
  assign resultGate  = result_gate_q;
  assign resultValid = result_valid_q;
  assign timeStep    = time_step_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_lstm_gate_scheduler.sv
// Self-checking bench for lstm_gate_scheduler. A procedural reference drives
// whole sequences (x handshake, gate replies with random latency/data, cell
// acks) and derives every expectation from the step/gate arithmetic.
module tb_lstm_gate_scheduler;

  localparam int HIDDEN_SZ = 16;
  localparam int QN        = 6;
  localparam int QM        = 11;
  localparam int SEQ_W     = 8;
  localparam int TMO       = 16;
  localparam int W         = (QN + QM + 1) * HIDDEN_SZ;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic             abort;
  logic [SEQ_W-1:0] seqLen;
  logic             inputValid;
  logic             inputReady;
  logic [1:0]       gateSel;
  logic             beginCalc;
  logic             dataReady_gate;
  logic [W-1:0]     gateOutput;
  logic [W-1:0]     resultVec;
  logic [1:0]       resultGate;
  logic             resultValid;
  logic             cellAck;
  logic [SEQ_W-1:0] timeStep;
  logic             busy;
  logic             done;
  logic             error;

  int n_checks = 0;
  int n_errors = 0;
  int begin_cnt = 0;
  int rv_cnt = 0;
  int done_cnt = 0;
  int overlap_cnt = 0;
  logic [W-1:0] last_data;

  lstm_gate_scheduler #(
    .HIDDEN_SZ(HIDDEN_SZ), .QN(QN), .QM(QM), .SEQ_W(SEQ_W), .TIMEOUT_CYC(TMO)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .seqLen(seqLen),
    .inputValid(inputValid), .inputReady(inputReady), .gateSel(gateSel),
    .beginCalc(beginCalc), .dataReady_gate(dataReady_gate), .gateOutput(gateOutput),
    .resultVec(resultVec), .resultGate(resultGate), .resultValid(resultValid),
    .cellAck(cellAck), .timeStep(timeStep), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Pulse counters, sampled mid-cycle.
  always @(negedge clock) begin
    if (beginCalc) begin_cnt = begin_cnt + 1;
    if (resultValid) rv_cnt = rv_cnt + 1;
    if (done) done_cnt = done_cnt + 1;
    if (beginCalc && inputReady) overlap_cnt = overlap_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_vec();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < (W + 31) / 32; k++) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq(tag, W'({inputReady, gateSel, beginCalc, resultGate, resultValid,
                      timeStep, busy, done, error}), W'(0));
    check_eq({tag, "_vec"}, resultVec, W'(0));
  endtask

  // One sequence. xdel<0: random x delay, 0: inputValid held high.
  // lat_fix=0: random gate latency. ab_step/ab_gate: abort point.
  // rst_step: pull reset in WAIT_ACK of that step. busy_start: stray start.
  task automatic run_seq(input int len, input int xdel, input int lat_fix,
                         input int ab_step, input int ab_gate, input int rst_step,
                         input bit busy_start);
    int b0, r0, d0, o0, lat, d;
    logic [W-1:0] data;
    b0 = begin_cnt; r0 = rv_cnt; d0 = done_cnt; o0 = overlap_cnt;
    start = 1'b1; seqLen = SEQ_W'(len);
    @(negedge clock);
    start = 1'b0; seqLen = '0;
    check_eq("start_ready", W'(inputReady), W'(1));
    check_eq("start_busy", W'(busy), W'(1));
    check_eq("start_err_clr", W'(error), W'(0));
    for (int s = 0; s < len; s++) begin
      d = (xdel < 0) ? int'($urandom_range(3, 0)) : xdel;
      repeat (d) begin
        check_eq("x_wait_ready", W'(inputReady), W'(1));
        @(negedge clock);
      end
      inputValid = 1'b1;
      @(negedge clock);
      if (xdel != 0) inputValid = 1'b0;
      check_eq("hs_begin", W'(beginCalc), W'(1));
      check_eq("hs_ready_drop", W'(inputReady), W'(0));
      check_eq("step_idx", W'(timeStep), W'(s));
      for (int g = 0; g < 4; g++) begin
        check_eq("gate_sel", W'(gateSel), W'(g));
        if (s == ab_step && g == ab_gate) begin
          repeat (2) @(negedge clock);
          abort = 1'b1;
          @(negedge clock);
          abort = 1'b0;
          check_eq("abort_busy", W'(busy), W'(0));
          check_eq("abort_begin", W'(beginCalc), W'(0));
          check_eq("abort_err", W'(error), W'(0));
          dataReady_gate = 1'b1; gateOutput = rand_vec();
          @(negedge clock);
          dataReady_gate = 1'b0;
          check_eq("late_dr_valid", W'(resultValid), W'(0));
          check_eq("late_dr_vec", resultVec, last_data);
          repeat (3) @(negedge clock);
          check_eq("abort_begin_cnt", W'(begin_cnt - b0), W'(4 * s + g + 1));
          inputValid = 1'b0;
          return;
        end
        lat = (lat_fix != 0) ? lat_fix : int'($urandom_range(10, 1));
        repeat (lat) begin
          @(negedge clock);
          check_eq("begin_one_cycle", W'(beginCalc), W'(0));
          check_eq("gsel_stable", W'(gateSel), W'(g));
        end
        data = rand_vec();
        dataReady_gate = 1'b1; gateOutput = data;
        @(negedge clock);
        dataReady_gate = 1'b0; gateOutput = rand_vec();
        check_eq("res_valid", W'(resultValid), W'(1));
        check_eq("res_gate", W'(resultGate), W'(g));
        check_eq("res_vec", resultVec, data);
        last_data = data;
        if (g < 3) begin
          @(negedge clock);
          check_eq("next_begin", W'(beginCalc), W'(1));
          check_eq("res_valid_pulse", W'(resultValid), W'(0));
        end
      end
      if (s == rst_step) begin
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_all_zero("rst_async");
        @(negedge clock);
        reset = 1'b1;
        inputValid = 1'b0;
        return;
      end
      @(negedge clock);
      dataReady_gate = 1'b1;
      if (busy_start && s == 0) begin start = 1'b1; seqLen = SEQ_W'(7); end
      @(negedge clock);
      dataReady_gate = 1'b0; start = 1'b0; seqLen = '0;
      check_eq("stray_dr", W'(resultValid), W'(0));
      check_eq("ack_wait_busy", W'(busy), W'(1));
      cellAck = 1'b1;
      @(negedge clock);
      cellAck = 1'b0;
      check_eq("ack_gsel0", W'(gateSel), W'(0));
      if (s == len - 1) begin
        check_eq("done_pulse", W'(done), W'(1));
        @(negedge clock);
        check_eq("done_once", W'(done), W'(0));
        check_eq("idle_busy", W'(busy), W'(0));
        check_eq("step_hold", W'(timeStep), W'(len - 1));
      end else begin
        check_eq("next_step_ready", W'(inputReady), W'(1));
        check_eq("next_step_idx", W'(timeStep), W'(s + 1));
      end
    end
    inputValid = 1'b0;
    check_eq("begin_total", W'(begin_cnt - b0), W'(4 * len));
    check_eq("valid_total", W'(rv_cnt - r0), W'(4 * len));
    check_eq("done_total", W'(done_cnt - d0), W'(1));
    check_eq("begin_vs_ready", W'(overlap_cnt - o0), W'(0));
    check_eq("run_err", W'(error), W'(0));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    reset = 1'b0; start = 1'b0; abort = 1'b0; seqLen = '0; inputValid = 1'b0;
    dataReady_gate = 1'b0; gateOutput = '0; cellAck = 1'b0; last_data = '0;
    repeat (2) @(negedge clock);
    check_all_zero("reset_state");
    reset = 1'b1;
    @(negedge clock);

    // single step, valid held, fixed 5-cycle gate
    run_seq(1, 0, 5, -1, -1, -1, 1'b0);
    // three steps with delayed inputs
    run_seq(3, 4, 0, -1, -1, -1, 1'b0);

    // gate never replies
    start = 1'b1; seqLen = SEQ_W'(1);
    @(negedge clock);
    start = 1'b0; seqLen = '0; inputValid = 1'b1;
    @(negedge clock);
    inputValid = 1'b0;
    check_eq("to_begin", W'(beginCalc), W'(1));
    n = 0;
    while (!error && n < 40) begin
      @(negedge clock);
      n++;
    end
    check_eq("to_cycles", W'(n), W'(TMO));
    check_eq("to_busy", W'(busy), W'(0));
    @(negedge clock);
    check_eq("to_busy_next", W'(busy), W'(0));
    check_eq("to_err_sticky", W'(error), W'(1));
    run_seq(1, -1, 0, -1, -1, -1, 1'b0);

    // abort during gate 2 of step 1
    run_seq(2, -1, 0, 1, 2, -1, 1'b0);

    // seqLen = 0
    start = 1'b1; seqLen = '0;
    @(negedge clock);
    start = 1'b0;
    check_eq("len0_err", W'(error), W'(1));
    check_eq("len0_busy", W'(busy), W'(0));
    // start and abort together
    start = 1'b1; abort = 1'b1; seqLen = SEQ_W'(3);
    @(negedge clock);
    start = 1'b0; abort = 1'b0; seqLen = '0;
    check_eq("start_abort_busy", W'(busy), W'(0));
    check_eq("start_abort_err", W'(error), W'(1));
    // start while busy is ignored
    run_seq(2, -1, 0, -1, -1, -1, 1'b1);

    // reset during WAIT_ACK, then a fresh run
    run_seq(2, -1, 0, -1, -1, 0, 1'b0);
    run_seq(2, -1, 0, -1, -1, -1, 1'b0);

    for (int r = 0; r < 4; r++) run_seq(int'($urandom_range(4, 1)), -1, 0, -1, -1, -1, 1'b0);

    // longest sequence
    run_seq(255, 0, 1, -1, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
